// File: rtl/instr_sequencer_if.sv
// Memory fetch port between the instruction sequencer (master) and instruction memory (slave).
interface instr_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: fetches 16-bit words into IR, decodes ALU controls,
// and steps EXEC/WB strobes in free-run or single-step mode.
module instr_sequencer #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned PC_RESET      = 0,
    parameter int unsigned EXEC_CYCLES   = 1,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_mode,
    input  logic                manual_plus,
    input  logic                halt,
    instr_sequencer_if.master   mem,
    output logic [ADDR_W-1:0]   pc,
    output logic [15:0]         ir,
    output logic [2:0]          S,
    output logic [3:0]          choose_reg,
    output logic [1:0]          res_dest,
    output logic                alu_en,
    output logic                wb_en,
    output logic [2:0]          state,
    output logic                error
);

    localparam int unsigned WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam int unsigned EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);
    localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_ir;
    logic [2:0]          r_s;
    logic [3:0]          r_choose_reg;
    logic [1:0]          r_res_dest;
    logic                r_error;
    logic                r_mp_d;
    logic [WAIT_W-1:0]   r_wait;
    logic [EXEC_W-1:0]   r_exec;

    logic                w_step;
    logic                w_timeout;
    logic [3:0]          w_opcode;

    assign w_step    = manual_plus & ~r_mp_d;
    assign w_timeout = (r_wait == WAIT_LAST);
    assign w_opcode  = r_ir[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (halt)                   w_next = HALT;
                else if (run_mode || w_step) w_next = FETCH;
            end
            FETCH: begin
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (mem.mem_ack)    w_next = DECODE;
                else if (w_timeout) w_next = HALT;
            end
            DECODE: begin
                case (w_opcode)
                    4'b0111, 4'b1000: w_next = EXEC;
                    4'b0000:          w_next = IDLE;
                    default:          w_next = HALT;
                endcase
            end
            EXEC: begin
                if (r_exec == '0) w_next = WB;
            end
            WB: begin
                if (halt)          w_next = HALT;
                else if (run_mode) w_next = FETCH;
                else               w_next = IDLE;
            end
            HALT:    w_next = HALT;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        alu_en       = 1'b0;
        wb_en        = 1'b0;
        case (r_state)
            FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = r_pc;
            end
            EXEC:    alu_en = 1'b1;
            WB:      wb_en  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= ADDR_W'(PC_RESET);
            r_ir         <= '0;
            r_s          <= '0;
            r_choose_reg <= '0;
            r_res_dest   <= '0;
            r_error      <= 1'b0;
            r_mp_d       <= 1'b0;
            r_wait       <= '0;
            r_exec       <= '0;
        end else begin
            r_mp_d <= manual_plus;
            case (r_state)
                FETCH: begin
                    if (mem.mem_ack) begin
                        r_ir   <= mem.mem_rdata;
                        r_pc   <= r_pc + 1'b1;
                        r_wait <= '0;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_wait  <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                DECODE: begin
                    case (w_opcode)
                        4'b0111: begin
                            r_s          <= 3'b011;
                            r_choose_reg <= r_ir[11:8];
                            r_res_dest   <= r_ir[7:6];
                            r_exec       <= EXEC_LAST;
                        end
                        4'b1000: begin
                            r_s          <= 3'b110;
                            r_choose_reg <= {r_ir[11:10], 2'b00};
                            r_res_dest   <= r_ir[9:8];
                            r_exec       <= EXEC_LAST;
                        end
                        4'b0000, 4'b1111: ;
                        default: r_error <= 1'b1;
                    endcase
                end
                EXEC: begin
                    if (r_exec != '0) r_exec <= r_exec - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pc         = r_pc;
    assign ir         = r_ir;
    assign S          = r_s;
    assign choose_reg = r_choose_reg;
    assign res_dest   = r_res_dest;
    assign error      = r_error;
    assign state      = r_state;

endmodule
